// File: rtl/mem_responder.sv
// mem_responder: unified instruction/data word memory serving a single core.
//
// The instruction side is a free-running fetch port: every enabled edge
// registers the word at programCounter into instruction. The data side is
// a request/response port driven by a small FSM that inserts WAIT_STATES
// extra cycles before each response, then pulses data_valid for one cycle.
//
// Ports
//   clk            core clock, rising edge
//   rst            asynchronous active-high reset (memory contents kept)
//   clk_en         clock enable; low freezes every register and the memory
//   programCounter fetch byte address (bits [1:0] ignored)
//   instruction    fetched word, 1-cycle latency, 0 when out of range
//   instr_valid    1 from the first enabled edge after reset onwards
//   data_req       data request, held by the core until data_valid
//   writeFlag      1 = store, 0 = load
//   addressIn      data byte address
//   dataOut        store data from the core
//   dataIn         load data / echoed store data / 0 on error
//   data_valid     one-cycle response strobe
//   err_bits       bit0 misaligned, bit1 out of range; held until next response
//
// Data FSM
//   state   | meaning
//   IDLE    | waiting for data_req; captures the request fields
//   WAIT    | counting down the inserted wait states
//   RESP    | access performed on entry; data_valid high for this cycle

module mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic [31:0] programCounter,
  output logic [31:0] instruction,
  output logic        instr_valid,
  input  logic        data_req,
  input  logic        writeFlag,
  input  logic [31:0] addressIn,
  input  logic [31:0] dataOut,
  output logic [31:0] dataIn,
  output logic        data_valid,
  output logic [1:0]  err_bits
);

  localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);
  localparam logic [3:0]  WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  logic [31:0] mem_q [DEPTH_WORDS];

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [31:0] instr_q, instr_d;
  logic        ivalid_q, ivalid_d;
  logic [31:0] din_q, din_d;
  logic [1:0]  err_q, err_d;

  logic          fetch_oor;
  logic [AW-1:0] fetch_idx;

  logic          acc_fire;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic          acc_we;
  logic          acc_mis;
  logic          acc_oor;
  logic [AW-1:0] acc_idx;

  logic          mem_we;
  logic [AW-1:0] mem_widx;
  logic [31:0]   mem_wdata;

  logic unused_pc;
  assign unused_pc = ^programCounter[1:0];

  assign fetch_oor = {2'b00, programCounter[31:2]} >= DEPTH_L;
  assign fetch_idx = programCounter[AW+1:2];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    instr_d   = instr_q;
    ivalid_d  = ivalid_q;
    din_d     = din_q;
    err_d     = err_q;
    acc_fire  = 1'b0;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_we    = we_q;
    mem_we    = 1'b0;
    mem_widx  = '0;
    mem_wdata = '0;

    if (clk_en) begin
      instr_d  = fetch_oor ? 32'h0 : mem_q[fetch_idx];
      ivalid_d = 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (data_req) begin
            addr_d  = addressIn;
            wdata_d = dataOut;
            we_d    = writeFlag;
            if (WAIT_STATES == 0) begin
              // With no wait states the capture edge is also the RESP entry
              // edge, so the access uses the fields being captured right now.
              state_d   = ST_RESP;
              acc_fire  = 1'b1;
              acc_addr  = addressIn;
              acc_wdata = dataOut;
              acc_we    = writeFlag;
            end else begin
              state_d = ST_WAIT;
              cnt_d   = WS_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_d  = ST_RESP;
            acc_fire = 1'b1;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        ST_RESP: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    acc_mis = acc_addr[1:0] != 2'b00;
    acc_oor = {2'b00, acc_addr[31:2]} >= DEPTH_L;
    acc_idx = acc_addr[AW+1:2];

    if (acc_fire) begin
      err_d = {acc_oor, acc_mis};
      if (acc_mis || acc_oor) begin
        din_d = 32'h0;
      end else if (acc_we) begin
        din_d     = acc_wdata;
        mem_we    = 1'b1;
        mem_widx  = acc_idx;
        mem_wdata = acc_wdata;
      end else begin
        din_d = mem_q[acc_idx];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      we_q     <= 1'b0;
      instr_q  <= 32'h0;
      ivalid_q <= 1'b0;
      din_q    <= 32'h0;
      err_q    <= 2'b00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      instr_q  <= instr_d;
      ivalid_q <= ivalid_d;
      din_q    <= din_d;
      err_q    <= err_d;
    end
  end

  // Memory is not reset. The fetch above reads mem_q combinationally and is
  // registered on the same edge as this write, so a same-word fetch sees the
  // old contents.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem_q[mem_widx] <= mem_wdata;
    end
  end

  assign instruction = instr_q;
  assign instr_valid = ivalid_q;
  assign dataIn      = din_q;
  assign data_valid  = (state_q == ST_RESP);
  assign err_bits    = err_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  localparam int DEPTH = 64;
  localparam int WS    = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic [31:0] programCounter;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        data_req;
  logic        writeFlag;
  logic [31:0] addressIn;
  logic [31:0] dataOut;
  logic [31:0] dataIn;
  logic        data_valid;
  logic [1:0]  err_bits;

  logic [31:0] z_pc;
  logic [31:0] z_instr;
  logic        z_iv;
  logic        z_req;
  logic        z_we;
  logic [31:0] z_addr;
  logic [31:0] z_dout;
  logic [31:0] z_din;
  logic        z_dv;
  logic [1:0]  z_err;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .programCounter(programCounter), .instruction(instruction), .instr_valid(instr_valid),
    .data_req(data_req), .writeFlag(writeFlag), .addressIn(addressIn), .dataOut(dataOut),
    .dataIn(dataIn), .data_valid(data_valid), .err_bits(err_bits)
  );

  mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut_z (
    .clk(clk), .rst(rst), .clk_en(1'b1),
    .programCounter(z_pc), .instruction(z_instr), .instr_valid(z_iv),
    .data_req(z_req), .writeFlag(z_we), .addressIn(z_addr), .dataOut(z_dout),
    .dataIn(z_din), .data_valid(z_dv), .err_bits(z_err)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state
  logic [31:0] mdl [DEPTH];
  logic [31:0] pend;
  logic [31:0] exp_instr;
  logic        iv_exp;
  bit          fetch_on;
  bit          rand_pc;
  bit          op_live;
  bit          op_we;
  logic [31:0] op_addr;
  logic [31:0] op_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_err(input logic [31:0] a);
    return {(a >> 2) >= 32'(DEPTH), a[1:0] != 2'b00};
  endfunction

  function automatic logic [31:0] mdl_read(input logic [31:0] a);
    int idx;
    if ((a >> 2) >= 32'(DEPTH)) return 32'h0;
    idx = int'(a >> 2);
    return mdl[idx];
  endfunction

  // One full clock: edge, then bookkeeping and fetch checking at negedge.
  task automatic cyc();
    bit en_edge, rst_edge;
    en_edge  = clk_en;
    rst_edge = rst;
    @(posedge clk);
    @(negedge clk);
    if (rst_edge) begin
      exp_instr = 32'h0;
      iv_exp    = 1'b0;
    end else if (en_edge) begin
      exp_instr = pend;
      iv_exp    = 1'b1;
    end
    if (op_live && data_valid && !rst_edge) begin
      if (op_we && exp_err(op_addr) == 2'b00) mdl[int'(op_addr >> 2)] = op_data;
      op_live = 1'b0;
    end
    if (fetch_on) begin
      chk("instr", instruction, exp_instr);
      chk("instr_valid", {31'b0, instr_valid}, {31'b0, iv_exp});
    end
    if (rand_pc) programCounter = $urandom_range(0, DEPTH * 8 - 1);
    pend = mdl_read(programCounter);
  endtask

  task automatic xact(input bit we, input logic [31:0] a, input logic [31:0] d, input bit stall);
    logic [31:0] exp_d;
    logic [1:0]  exp_e;
    int          n;
    int          exp_n;
    bit          got;
    exp_e = exp_err(a);
    exp_d = (exp_e != 2'b00) ? 32'h0 : (we ? d : mdl_read(a));
    exp_n = WS + 1 + (stall ? 3 : 0);
    writeFlag = we;
    addressIn = a;
    dataOut   = d;
    data_req  = 1'b1;
    op_live   = 1'b1;
    op_we     = we;
    op_addr   = a;
    op_data   = d;
    n   = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      clk_en = !(stall && n + 1 >= 2 && n + 1 <= 4);
      cyc();
      n++;
      if (data_valid) got = 1'b1;
    end
    clk_en = 1'b1;
    if (!got) begin
      chk("timeout", 32'(n), 32'(exp_n));
    end else begin
      chk("latency", 32'(n), 32'(exp_n));
      chk("dataIn", dataIn, exp_d);
      chk("err_bits", {30'b0, err_bits}, {30'b0, exp_e});
    end
    data_req = 1'b0;
    cyc();
    chk("single_pulse", {31'b0, data_valid}, 32'h0);
    chk("err_hold", {30'b0, err_bits}, {30'b0, exp_e});
  endtask

  initial begin
    logic [31:0] a, old20;
    rst = 1'b0; clk_en = 1'b1; programCounter = 32'h0;
    data_req = 1'b0; writeFlag = 1'b0; addressIn = 32'h0; dataOut = 32'h0;
    z_pc = 32'h0; z_req = 1'b0; z_we = 1'b0; z_addr = 32'h0; z_dout = 32'h0;
    fetch_on = 1'b0; rand_pc = 1'b1; op_live = 1'b0; op_we = 1'b0;
    op_addr = 32'h0; op_data = 32'h0; pend = 32'h0; exp_instr = 32'h0; iv_exp = 1'b0;
    for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;

    #2 rst = 1'b1;
    #1;
    chk("rst_instr", instruction, 32'h0);
    chk("rst_iv", {31'b0, instr_valid}, 32'h0);
    chk("rst_dataIn", dataIn, 32'h0);
    chk("rst_dv", {31'b0, data_valid}, 32'h0);
    chk("rst_err", {30'b0, err_bits}, 32'h0);
    @(negedge clk);
    cyc();
    rst = 1'b0;

    // fill the memory so every fetch/load has a known expectation
    for (int i = 0; i < DEPTH; i++) xact(1'b1, 32'(i * 4), $urandom, 1'b0);
    fetch_on = 1'b1;

    // store then load back
    xact(1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    xact(1'b0, 32'h10, 32'h0, 1'b0);
    chk("s037_load", dataIn, 32'hDEADBEEF);

    // directed fetch of word 3 with aligned and unaligned PC
    xact(1'b1, 32'h0C, 32'h12345678, 1'b0);
    rand_pc = 1'b0;
    programCounter = 32'h0C;
    pend = mdl_read(programCounter);
    cyc();
    chk("s038_pc0c", instruction, 32'h12345678);
    programCounter = 32'h0E;
    pend = mdl_read(programCounter);
    cyc();
    chk("s038_pc0e", instruction, 32'h12345678);
    rand_pc = 1'b1;

    // error cases
    xact(1'b1, 32'h11, 32'hCAFEF00D, 1'b0);
    xact(1'b0, 32'h10, 32'h0, 1'b0);
    chk("s039_unchanged", dataIn, 32'hDEADBEEF);
    xact(1'b0, 32'(DEPTH * 4), 32'h0, 1'b0);
    xact(1'b1, 32'(DEPTH * 4 + 1), 32'h1, 1'b0);

    // reset during WAIT abandons the store
    old20 = mdl_read(32'h20);
    writeFlag = 1'b1; addressIn = 32'h20; dataOut = 32'hA5A5A5A5; data_req = 1'b1;
    op_live = 1'b1; op_we = 1'b1; op_addr = 32'h20; op_data = 32'hA5A5A5A5;
    cyc();
    rst = 1'b1;
    #1;
    chk("s040_instr", instruction, 32'h0);
    chk("s040_iv", {31'b0, instr_valid}, 32'h0);
    chk("s040_dataIn", dataIn, 32'h0);
    chk("s040_dv", {31'b0, data_valid}, 32'h0);
    chk("s040_err", {30'b0, err_bits}, 32'h0);
    op_live = 1'b0;
    data_req = 1'b0;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("s040_no_dv", {31'b0, data_valid}, 32'h0);
    end
    xact(1'b0, 32'h20, 32'h0, 1'b0);
    chk("s040_old", dataIn, old20);

    // clock-enable stall in WAIT
    xact(1'b1, 32'h24, 32'h01020304, 1'b1);
    xact(1'b0, 32'h24, 32'h0, 1'b1);

    // zero-wait-state instance: read-before-write on fetch
    z_req = 1'b1; z_we = 1'b1; z_addr = 32'h8; z_dout = 32'h0;
    cyc();
    chk("z_lat", {31'b0, z_dv}, 32'h1);
    z_req = 1'b0;
    cyc();
    z_pc = 32'h8; z_req = 1'b1; z_we = 1'b1; z_addr = 32'h8; z_dout = 32'h1;
    cyc();
    chk("s041_old", z_instr, 32'h0);
    chk("s041_dv", {31'b0, z_dv}, 32'h1);
    chk("s041_din", z_din, 32'h1);
    chk("s041_err", {30'b0, z_err}, 32'h0);
    z_req = 1'b0;
    cyc();
    chk("s041_new", z_instr, 32'h1);
    chk("s041_dv_off", {31'b0, z_dv}, 32'h0);
    z_req = 1'b1; z_we = 1'b1; z_addr = 32'h9; z_dout = 32'hFF;
    cyc();
    chk("z_mis_err", {30'b0, z_err}, 32'h1);
    chk("z_mis_din", z_din, 32'h0);
    z_req = 1'b0;
    cyc();
    z_req = 1'b1; z_we = 1'b0; z_addr = 32'h8;
    cyc();
    chk("z_load", z_din, 32'h1);
    z_req = 1'b0;
    cyc();

    // randomized traffic against the model
    for (int i = 0; i < 200; i++) begin
      a = $urandom_range(0, DEPTH * 4 + 15);
      if ($urandom_range(0, 3) != 0) a = a & ~32'h3;
      xact(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 7) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
